cs_sub32_serial: RTL and testbench

Digit-serial 32-bit subtractor computing d = a - b - bin, M bits per clock. It is the sequential subtract-side counterpart to the team's combinational 32-bit carry-select adder, for datapaths that trade latency for area. Each digit slice is a carry-select stage: both carry assumptions are precomputed and the registered carry picks one. Valid/ready handshakes sit on input and output.

---
 rtl/cs_sub32_serial.sv | 105 ++++++++++
 tb/tb_cs_sub32_serial.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/cs_sub32_serial.sv
// cs_sub32_serial: digit-serial n-bit subtractor d = a - b - bin, m bits per cycle, LSB first.
// Each digit is a carry-select slice; the registered carry picks the precomputed sum.
module cs_sub32_serial #(
    parameter int n = 32,
    parameter int m = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] d,
    output logic         bout,
    output logic         z,
    output logic         v
);
    localparam int STEPS = n / m;
    localparam int KW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [KW-1:0] LAST = KW'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state;
    logic [n-1:0]    r_a;
    logic [n-1:0]    r_b;
    logic [n-1:0]    r_d;
    logic [KW-1:0]   r_k;
    logic            r_carry;
    logic            r_bout;
    logic            r_z;
    logic            r_v;
    logic            r_out_valid;

    logic [m-1:0]    w_a_dig;
    logic [m-1:0]    w_b_dig;
    logic [m:0]      w_s0;
    logic [m:0]      w_s1;
    logic [m:0]      w_sel;
    logic [n-1:0]    w_d_next;

    // Subtraction as a + ~b + carry, with the carry initialised to ~bin.
    always_comb begin
        w_a_dig  = r_a[r_k*m +: m];
        w_b_dig  = r_b[r_k*m +: m];
        w_s0     = {1'b0, w_a_dig} + {1'b0, ~w_b_dig};
        w_s1     = {1'b0, w_a_dig} + {1'b0, ~w_b_dig} + (m+1)'(1);
        w_sel    = r_carry ? w_s1 : w_s0;
        w_d_next = r_d;
        w_d_next[r_k*m +: m] = w_sel[m-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_d         <= '0;
            r_k         <= '0;
            r_carry     <= 1'b0;
            r_bout      <= 1'b0;
            r_z         <= 1'b0;
            r_v         <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a     <= a;
                    r_b     <= b;
                    r_carry <= ~bin;
                    r_k     <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    r_d     <= w_d_next;
                    r_carry <= w_sel[m];
                    if (r_k == LAST) begin
                        r_bout      <= ~w_sel[m];
                        r_z         <= ~|w_d_next;
                        r_v         <= (r_a[n-1] ^ r_b[n-1]) & (w_d_next[n-1] ^ r_a[n-1]);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign d         = r_d;
    assign bout      = r_bout;
    assign z         = r_z;
    assign v         = r_v;
endmodule

// File: tb/tb_cs_sub32_serial.sv
// tb_cs_sub32_serial: directed checks of the serial subtractor with immediate assertions.
module tb_cs_sub32_serial;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] d;
    logic        bout;
    logic        z;
    logic        v;
    int          errors = 0;
    int          checks = 0;
    int          cnt;

    cs_sub32_serial dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .d(d), .bout(bout), .z(z), .v(v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, take the accept edge, then count edges until out_valid.
    task automatic start_and_wait(input logic [31:0] ta, input logic [31:0] tb_, input logic tbin, input string tag);
        a = ta;
        b = tb_;
        bin = tbin;
        in_valid = 1'b1;
        chk({tag, "_in_ready_before"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        chk({tag, "_latency"}, 32'(cnt), 32'd8);
    endtask

    task automatic check_result(input string tag, input logic [31:0] ed, input logic eb, input logic ez, input logic ev);
        chk({tag, "_d"}, d, ed);
        chk({tag, "_bout"}, 32'(bout), 32'(eb));
        chk({tag, "_z"}, 32'(z), 32'(ez));
        chk({tag, "_v"}, 32'(v), 32'(ev));
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_out_valid_cleared"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_d", d, 32'd0);
        chk("reset_flags", {29'd0, bout, z, v}, 32'd0);

        // Reset three cycles into RUN aborts the operation asynchronously.
        a = 32'h5;
        b = 32'h3;
        bin = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("midrun_d_partial", d, 32'h2);
        chk("midrun_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
        chk("midrun_rst_d", d, 32'd0);
        #1;
        rst = 1'b0;
        tick();

        start_and_wait(32'h00000005, 32'h00000003, 1'b0, "t2");
        check_result("t2", 32'h00000002, 1'b0, 1'b0, 1'b0);
        release_result("t2");

        start_and_wait(32'h00000000, 32'h00000001, 1'b0, "t3");
        check_result("t3", 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        release_result("t3");

        start_and_wait(32'h80000000, 32'h00000001, 1'b0, "t4");
        check_result("t4", 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
        release_result("t4");

        start_and_wait(32'h12345678, 32'h12345677, 1'b1, "t5");
        check_result("t5", 32'h00000000, 1'b0, 1'b1, 1'b0);
        release_result("t5");

        start_and_wait(32'h00000000, 32'h00000000, 1'b1, "bin_only");
        check_result("bin_only", 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        release_result("bin_only");

        // Back-pressure: result held while new operands wait on the input.
        start_and_wait(32'h00000009, 32'h00000004, 1'b1, "bp1");
        a = 32'h00000100;
        b = 32'h00000001;
        bin = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_d", d, 32'h00000004);
            chk("bp_hold_out_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_flags", {29'd0, bout, z, v}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp2_accepted", 32'(in_ready), 32'd0);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("bp2_latency", 32'(cnt), 32'd8);
        check_result("bp2", 32'h000000FF, 1'b0, 1'b0, 1'b0);
        release_result("bp2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
